// File: rtl/debug_mem_reader.sv
// debug_mem_reader: walks data-memory word addresses 0..num_words-1 through
// the memory debug read port and streams every word MSB-byte-first to the
// UART transmitter using a one-byte start/done handshake. A done pulse tells
// the debug unit FSM that the dump is complete.
//
// Optional build macro DEBUG_DUMP_CHECKSUM_EN: when defined, an 8-bit XOR of
// all transmitted data bytes is appended as one extra byte after the last
// word, and done follows that byte instead of the last data byte.
module debug_mem_reader #(
    parameter int len_data  = 32,
    parameter int len_addr  = 6,
    parameter int num_words = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [len_data-1:0] in_data_debug,
    input  logic                tx_done,
    output logic [len_addr-1:0] out_addr_debug,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    output logic                busy,
    output logic                done
);

    localparam int BytesPerWord = len_data / 8;
    localparam int IdxW         = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;
    localparam logic [IdxW-1:0]     LastIdx  = IdxW'(BytesPerWord - 1);
    localparam logic [len_addr-1:0] LastAddr = len_addr'(num_words - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LATCH,
        S_SEND,
        S_WAIT,
        S_NEXT
`ifdef DEBUG_DUMP_CHECKSUM_EN
        ,
        S_CSUM,
        S_CSUM_WAIT
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [len_addr-1:0] addr_q, addr_d;
    logic [len_data-1:0] word_q, word_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [len_data-1:0] wordShifted;
    logic [7:0]          curByte;

    // Shifting the latched word left by whole bytes brings the byte at the
    // current index into the top byte lane, so index 0 is the MSB byte.
    assign wordShifted    = word_q << {idx_q, 3'b000};
    assign curByte        = wordShifted[len_data-1 -: 8];
    assign out_addr_debug = addr_q;

`ifdef DEBUG_DUMP_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    // Running XOR of transmitted data bytes; cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    // State, address, word latch and byte index registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state and output decode for the dump sequence.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        word_d   = word_q;
        idx_d    = idx_q;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        done     = 1'b0;
        busy     = (state_q != S_IDLE);
`ifdef DEBUG_DUMP_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = '0;
                    state_d = S_ADDR;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end
            end
            S_ADDR: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                word_d  = in_data_debug;
                idx_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                tx_data  = curByte;
                tx_start = 1'b1;
                state_d  = S_WAIT;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                csum_d   = csum_q ^ curByte;
`endif
            end
            S_WAIT: begin
                tx_data = curByte;
                if (tx_done) begin
                    if (idx_q == LastIdx) begin
                        state_d = S_NEXT;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_SEND;
                    end
                end
            end
            S_NEXT: begin
                if (addr_q == LastAddr) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    done    = 1'b1;
                    addr_d  = '0;
                    state_d = S_IDLE;
`endif
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_ADDR;
                end
            end
`ifdef DEBUG_DUMP_CHECKSUM_EN
            S_CSUM: begin
                tx_data  = csum_q;
                tx_start = 1'b1;
                state_d  = S_CSUM_WAIT;
            end
            S_CSUM_WAIT: begin
                tx_data = csum_q;
                if (tx_done) begin
                    done    = 1'b1;
                    addr_d  = '0;
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
